// File: rtl/hex_display_pkg.sv
// Shared types and constants for the seven-segment hex display controller.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble-to-segment decoder, active-low gfedcba.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  always_comb begin
    unique case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h18;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h27;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit hex display controller: one shared decoder scans digits, then commits all at once.
// Optional leading-zero blanking is enabled by defining HEX_DISPLAY_LZB_EN.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic [NUM_DIGITS-1:0]     dp,
  output logic                      ready,
  output logic                      load_drop,
  output logic [7*NUM_DIGITS-1:0]   segments,
  output logic [NUM_DIGITS-1:0]     dp_n
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [4*NUM_DIGITS-1:0]   value_q;
  logic [NUM_DIGITS-1:0]     blink_q;
  logic [NUM_DIGITS-1:0]     dp_q;
  seg_t                      shadow_q [NUM_DIGITS];
  seg_t                      disp_q   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     disp_blink_q;
  logic [NUM_DIGITS-1:0]     disp_dp_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      phase_q;
  logic                      ready_q;
  logic                      load_drop_q;
  logic [7*NUM_DIGITS-1:0]   segments_q;
  logic [NUM_DIGITS-1:0]     dp_n_q;

  logic [3:0] scan_nibble;
  seg_t       scan_seg;
  seg_t       commit_seg [NUM_DIGITS];

  always_comb begin
    scan_nibble = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) scan_nibble = value_q[4*d +: 4];
    end
  end

  hex_seg_decode u_dec (
    .nibble_i (scan_nibble),
    .seg_o    (scan_seg)
  );

`ifdef HEX_DISPLAY_LZB_EN
  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    commit_seg[0] = shadow_q[0];
    for (int unsigned d = NUM_DIGITS - 1; d >= 1; d--) begin
      all_zero      = all_zero && (value_q[4*d +: 4] == 4'h0);
      commit_seg[d] = all_zero ? SEG_OFF : shadow_q[d];
    end
  end
`else
  always_comb begin
    for (int unsigned d = 0; d < NUM_DIGITS; d++) commit_seg[d] = shadow_q[d];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      value_q      <= '0;
      blink_q      <= '0;
      dp_q         <= '0;
      disp_blink_q <= '0;
      disp_dp_q    <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      ready_q      <= 1'b1;
      load_drop_q  <= 1'b0;
      segments_q   <= '1;
      dp_n_q       <= '1;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        shadow_q[d] <= '0;
        disp_q[d]   <= SEG_OFF;
      end
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        segments_q[7*d +: 7] <= (phase_q && disp_blink_q[d]) ? SEG_OFF : disp_q[d];
        dp_n_q[d]            <= (phase_q && disp_blink_q[d]) ? 1'b1 : ~disp_dp_q[d];
      end

      if (load && !ready_q) load_drop_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (load) begin
            value_q <= value;
            blink_q <= blink_mask;
            dp_q    <= dp;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) shadow_q[d] <= scan_seg;
          end
          if (idx_q == IDX_LAST) state_q <= COMMIT;
          else                   idx_q   <= idx_q + 1'b1;
        end
        COMMIT: begin
          for (int unsigned d = 0; d < NUM_DIGITS; d++) disp_q[d] <= commit_seg[d];
          disp_dp_q    <= dp_q;
          disp_blink_q <= blink_q;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign load_drop = load_drop_q;
  assign segments  = segments_q;
  assign dp_n      = dp_n_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (NUM_DIGITS=6, BLINK_DIV=4).
module tb_hex_display_ctrl;

  localparam int unsigned N = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0]   blink_mask = '0;
  logic [N-1:0]   dp = '0;
  logic           ready;
  logic           load_drop;
  logic [7*N-1:0] segments;
  logic [N-1:0]   dp_n;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .blink_mask (blink_mask),
    .dp         (dp),
    .ready      (ready),
    .load_drop  (load_drop),
    .segments   (segments),
    .dp_n       (dp_n)
  );

  // Reference blink phase: 4-cycle half period; outputs lag the phase by one edge.
  int unsigned m_cnt = 0;
  logic        m_phase = 1'b0;
  logic        ph_seen = 1'b0;
  always @(posedge clk) begin
    ph_seen <= m_phase;
    if (reset) begin
      m_cnt   <= 0;
      m_phase <= 1'b0;
    end else if (m_cnt == 3) begin
      m_cnt   <= 0;
      m_phase <= ~m_phase;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] m, input logic [N-1:0] p);
    value = v;
    blink_mask = m;
    dp = p;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_ready(output int unsigned low);
    low = 0;
    while (!ready && low < 30) begin
      low++;
      tick();
    end
  endtask

  localparam logic [7*N-1:0] BLANK = {N{7'h7F}};
`ifdef HEX_DISPLAY_LZB_EN
  localparam logic [7*N-1:0] EXP_0123AF = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E};
  localparam logic [7*N-1:0] EXP_C5     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h27, 7'h12};
  localparam logic [6:0]     EXP_ZERO_D1 = 7'h7F;
`else
  localparam logic [7*N-1:0] EXP_0123AF = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E};
  localparam logic [7*N-1:0] EXP_C5     = {7'h40, 7'h40, 7'h40, 7'h40, 7'h27, 7'h12};
  localparam logic [6:0]     EXP_ZERO_D1 = 7'h40;
`endif

  initial begin
    int unsigned low;
    logic [3:0]  nib;

    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_seg", segments, BLANK);
    check("rst_dpn", dp_n, 6'h3F);
    check("rst_ready", ready, 1'b1);
    check("rst_drop", load_drop, 1'b0);

    do_load(24'h0123AF, '0, '0);
    check("busy_ready", ready, 1'b0);
    wait_ready(low);
    check("busy_cycles", low, 7);
    check("hold_seg", segments, BLANK);
    tick();
    check("disp_0123AF", segments, EXP_0123AF);
    check("no_drop", load_drop, 1'b0);

    do_load(24'h111111, '0, '0);
    tick();
    tick();
    value = 24'h222222;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("drop_set", load_drop, 1'b1);
    wait_ready(low);
    tick();
    check("drop_disp", segments, {N{7'h79}});
    repeat (5) tick();
    check("drop_sticky", load_drop, 1'b1);

    do_load(24'h000008, 6'b000001, '0);
    wait_ready(low);
    tick();
    check("blink_dpn", dp_n, 6'h3F);
    for (int i = 0; i < 12; i++) begin
      check("blink_d0", segments[6:0], ph_seen ? 7'h7F : 7'h00);
      check("blink_d1", segments[13:7], EXP_ZERO_D1);
      tick();
    end

    do_load(24'h654321, '0, '0);
    tick();
    tick();
    reset = 1'b1;
    load = 1'b1;
    tick();
    reset = 1'b0;
    load = 1'b0;
    check("mid_rst_seg", segments, BLANK);
    check("mid_rst_dpn", dp_n, 6'h3F);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_drop", load_drop, 1'b0);
    tick();
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_drop", load_drop, 1'b0);
    do_load(24'h0000C5, '0, 6'b000001);
    wait_ready(low);
    check("rst_busy_cycles", low, 7);
    check("rst_hold_seg", segments, BLANK);
    tick();
    check("disp_C5", segments, EXP_C5);
    check("dp_C5", dp_n, 6'b111110);

    for (int v = 0; v < 16; v++) begin
      nib = 4'(v);
      do_load({20'h0, nib}, '0, 6'b000001);
      wait_ready(low);
      tick();
      check($sformatf("dec_%0h", v), segments[6:0], tbl[v]);
      check("dec_dp", dp_n[0], 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised N-digit hexadecimal display controller for the DE10-Lite active-low seven-segment displays.
- Accepts a packed multi-nibble value through a load/ready handshake.
- Decodes one digit per cycle through a single shared decoder, then commits all digits to the displays at once.
- Adds per-digit blink and decimal-point control. Sits between datapath registers and the HEX0..HEX(N-1) pins.

Parameters:
- NUM_DIGITS, 6: number of displays driven (1..8).
- BLINK_DIV, 25_000_000: clock cycles per blink half-period (1 Hz blink at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- load  in  1  request to latch new value; accepted only when ready=1
- value  in  4*NUM_DIGITS  packed nibbles; digit d = value[4d+3:4d], digit 0 rightmost
- blink_mask  in  NUM_DIGITS  per-digit blink enable, latched with load
- dp  in  NUM_DIGITS  per-digit decimal point (1 = lit), latched with load
- ready  out  1  controller idle, load will be accepted
- load_drop  out  1  sticky: a load arrived while ready=0
- segments  out  7*NUM_DIGITS  active-low gfedcba per digit, digit d = segments[7d+6:7d]
- dp_n  out  NUM_DIGITS  active-low decimal points

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high; all state is updated on the rising edge of clk.
- Reset values:
  - segments all 7'h7F (blank); dp_n all 1.
  - ready=1, load_drop=0.
  - State IDLE; blink counter 0; blink_phase 0.
  - Latched value, masks and shadow registers all 0.
- Decode table, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18, A=08, b=03, C=27, d=21, E=06, F=0E (hex).
- FSM states IDLE, SCAN, COMMIT:
  - IDLE: ready=1. On edge E0 with load=1, latch value, blink_mask and dp; set idx=0; go to SCAN.
  - SCAN: each edge writes decode(value_q digit idx) into shadow[idx] and increments idx. After idx=NUM_DIGITS-1 (edge E_N), go to COMMIT.
  - COMMIT: edge E_(N+1) copies shadow into the display register, copies dp_q and blink_q, and returns to IDLE.
  - ready=0 from after E0 through E_(N+1).
- Output register updates every cycle: segments[d] <= (blink_phase && blink_q[d]) ? 7'h7F : disp[d]. dp_n is blanked the same way.
- Latency: new digits are visible after edge E_(N+2), i.e. load-to-display latency is N+2 cycles. ready=1 again after E_(N+1).
- Loads while ready=0 are ignored (no queueing) and set load_drop. load_drop clears only on reset.
- The display holds its previous contents during SCAN; there is no partial update.
- Blink counter runs freely 0..BLINK_DIV-1. blink_phase toggles on each wrap, independent of the FSM.
- Reset mid-scan aborts the scan: outputs blank, ready=1 on the cycle after reset deasserts. load asserted together with reset is ignored and does not set load_drop.
- idx width is clog2(NUM_DIGITS), minimum 1. NUM_DIGITS=1 gives one SCAN cycle.

Optional Feature:
- Macro: HEX_DISPLAY_LZB_EN.
- Defined: leading-zero blanking, evaluated at COMMIT from value_q. Digit d>0 commits as 7'h7F when all nibbles d..N-1 are 0. Digit 0 is never blanked. dp is unaffected.
- Not defined: every digit always shows its decoded nibble, including zeros.

Decomposition:
- Package hex_display_pkg:
  - SEG_OFF = 7'h7F.
  - typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t.
  - typedef logic [6:0] seg_t.
- Sub-module hex_seg_decode: purely combinational 4-bit to seg_t decoder implementing the table above. Instantiated once and shared across SCAN cycles.

Test Plan (NUM_DIGITS=6, BLINK_DIV=4):
- Reset, then idle 10 cycles -> segments all 7'h7F, dp_n=6'h3F, ready=1, load_drop=0.
- load value=24'h0123AF, masks 0 at E0 -> ready low for 7 cycles. After E8 segments digits 0..5 = 0E,08,30,24,79,40 (blank digit 5 when LZB_EN).
- Pulse load again at E3 during SCAN -> ignored, load_drop=1 and stays 1. Display reflects only the first value.
- blink_mask=6'b000001, value 24'h000008 -> digit 0 alternates 00/7F every 4 cycles; other digits steady.
- Assert reset at E3 mid-SCAN -> next cycle outputs blank, FSM IDLE, ready=1. A subsequent load completes normally with N+2 latency.
- Step value through 0x0..0xF on digit 0 -> each result matches the decode table; dp=1 gives dp_n[0]=0.
